// File: rtl/aes_round_sequencer.sv
// AES round controller: on an accepted start it walks round 0..Nr (cipher) then Nr+1..2*Nr
// (decipher) at a prescaled rate, then holds at 2*Nr until the next valid start.
module aes_round_sequencer #(
   parameter int STEP_DIV = 1,
   parameter int NR_BASE  = 10
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [1:0] key_sel_i,
   input  logic       step_en_i,
   output logic [4:0] round_o,
   output logic [1:0] mode_o,
   output logic [3:0] nr_o,
   output logic       busy_o,
   output logic       enc_phase_o,
   output logic       dec_phase_o,
   output logic       enc_done_o,
   output logic       done_o,
   output logic       err_o
);

   localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ENC, S_DEC, S_HOLD} state_e;

   state_e          state_q, state_d;
   logic [4:0]      round_q, round_d;
   logic [1:0]      mode_q, mode_d;
   logic [3:0]      nr_q, nr_d;
   logic [PW-1:0]   psc_q, psc_d;
   logic            enc_done_q, enc_done_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic idle_or_hold, accept, reject, tick, last_enc, last_dec;

   always_comb begin
      idle_or_hold = (state_q == S_IDLE) || (state_q == S_HOLD);
      accept       = idle_or_hold && start_i && (key_sel_i != 2'd3);
      reject       = idle_or_hold && start_i && (key_sel_i == 2'd3);
      tick         = step_en_i && (psc_q == PW'(STEP_DIV - 1));
      last_enc     = (round_q == {1'b0, nr_q});
      last_dec     = (round_q == ({nr_q, 1'b0} - 5'd1));
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_HOLD: if (accept)             state_d = S_ENC;
         S_ENC:          if (tick && last_enc)   state_d = S_DEC;
         S_DEC:          if (tick && last_dec)   state_d = S_HOLD;
         default:                                state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from registers only
   always_comb begin
      busy_o      = (state_q == S_ENC) || (state_q == S_DEC);
      enc_phase_o = (state_q != S_IDLE) && (round_q <= {1'b0, nr_q});
      dec_phase_o = (state_q != S_IDLE) && (round_q >  {1'b0, nr_q});
      round_o     = round_q;
      mode_o      = mode_q;
      nr_o        = nr_q;
      enc_done_o  = enc_done_q;
      done_o      = done_q;
      err_o       = err_q;
   end

   // Datapath next-state; a start accept overrides any same-cycle tick
   always_comb begin
      round_d    = round_q;
      mode_d     = mode_q;
      nr_d       = nr_q;
      psc_d      = psc_q;
      enc_done_d = 1'b0;
      done_d     = 1'b0;
      err_d      = reject;
      if (step_en_i) psc_d = tick ? '0 : psc_q + PW'(1);
      if (accept) begin
         round_d = '0;
         psc_d   = '0;
         mode_d  = key_sel_i;
         nr_d    = 4'(NR_BASE) + 4'({key_sel_i, 1'b0});
      end else if (tick && busy_o) begin
         round_d    = round_q + 5'd1;
         enc_done_d = (state_q == S_ENC) && last_enc;
         done_d     = (state_q == S_DEC) && last_dec;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         round_q    <= '0;
         mode_q     <= '0;
         nr_q       <= 4'(NR_BASE);
         psc_q      <= '0;
         enc_done_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         round_q    <= round_d;
         mode_q     <= mode_d;
         nr_q       <= nr_d;
         psc_q      <= psc_d;
         enc_done_q <= enc_done_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench: a STEP_DIV=1 instance for full-rate runs, reject, mid-run start, reset and
// restart from HOLD; a STEP_DIV=4 instance for prescaled stepping with step_en pauses.
module tb_aes_round_sequencer;

   logic       clk, rst;
   logic       start, step_en;
   logic [1:0] key_sel;
   logic [4:0] round;
   logic [1:0] mode;
   logic [3:0] nr;
   logic       busy, enc_phase, dec_phase, enc_done, done, err;

   logic       start4, step_en4;
   logic [1:0] key_sel4;
   logic [4:0] round4;
   logic [1:0] mode4;
   logic [3:0] nr4;
   logic       busy4, enc_phase4, dec_phase4, enc_done4, done4, err4;

   int checks = 0;
   int errors = 0;

   aes_round_sequencer #(.STEP_DIV(1), .NR_BASE(10)) u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .key_sel_i(key_sel), .step_en_i(step_en),
      .round_o(round), .mode_o(mode), .nr_o(nr), .busy_o(busy), .enc_phase_o(enc_phase),
      .dec_phase_o(dec_phase), .enc_done_o(enc_done), .done_o(done), .err_o(err)
   );

   aes_round_sequencer #(.STEP_DIV(4), .NR_BASE(10)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start4), .key_sel_i(key_sel4), .step_en_i(step_en4),
      .round_o(round4), .mode_o(mode4), .nr_o(nr4), .busy_o(busy4), .enc_phase_o(enc_phase4),
      .dec_phase_o(dec_phase4), .enc_done_o(enc_done4), .done_o(done4), .err_o(err4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_round"}, round, 0);
      chk({tag, "_mode"}, mode, 0);
      chk({tag, "_nr"}, nr, 10);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_encph"}, enc_phase, 0);
      chk({tag, "_decph"}, dec_phase, 0);
      chk({tag, "_encdone"}, enc_done, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   // Full-rate run from IDLE/HOLD; optional extra start (key_sel=0) at round inj
   task automatic run(input string tag, input logic [1:0] ks, input int exp_nr, input int inj);
      start = 1'b1; key_sel = ks;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k <= 2 * exp_nr; k++) begin
         chk({tag, "_round"}, round, k);
         chk({tag, "_encdone"}, enc_done, k == exp_nr + 1);
         chk({tag, "_done"}, done, k == 2 * exp_nr);
         chk({tag, "_busy"}, busy, k < 2 * exp_nr);
         chk({tag, "_encph"}, enc_phase, k <= exp_nr);
         chk({tag, "_decph"}, dec_phase, k > exp_nr);
         chk({tag, "_mode"}, mode, ks);
         chk({tag, "_nr"}, nr, exp_nr);
         if (k == inj) begin start = 1'b1; key_sel = 2'd0; end
         else start = 1'b0;
         @(negedge clk);
      end
      for (int h = 0; h < 3; h++) begin
         chk({tag, "_hold_round"}, round, 2 * exp_nr);
         chk({tag, "_hold_busy"}, busy, 0);
         chk({tag, "_hold_decph"}, dec_phase, 1);
         chk({tag, "_hold_done"}, done, 0);
         @(negedge clk);
      end
   endtask

   initial begin
      int  exp_round, exp_psc;
      bit  exp_encdone, exp_done, tk;

      rst = 1'b1; start = 1'b0; key_sel = 2'd0; step_en = 1'b1;
      start4 = 1'b0; key_sel4 = 2'd0; step_en4 = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_state("rst");
      chk("rst4_nr", nr4, 10);
      chk("rst4_round", round4, 0);
      rst = 1'b0;
      @(negedge clk);

      // T2: AES-256, STEP_DIV=4, step_en 1/0 every 3 cycles
      start4 = 1'b1; key_sel4 = 2'd2;
      @(negedge clk);
      start4 = 1'b0;
      exp_round = 0; exp_psc = 0; exp_encdone = 0; exp_done = 0;
      for (int cyc = 0; cyc < 260; cyc++) begin
         chk("t2_round", round4, exp_round);
         chk("t2_encdone", enc_done4, exp_encdone);
         chk("t2_done", done4, exp_done);
         chk("t2_encph", enc_phase4, exp_round <= 14);
         step_en4    = ((cyc / 3) % 2) == 0;
         tk          = step_en4 && (exp_psc == 3);
         exp_encdone = tk && (exp_round == 14);
         exp_done    = tk && (exp_round == 27);
         if (step_en4) exp_psc = (exp_psc == 3) ? 0 : exp_psc + 1;
         if (tk && exp_round < 28) exp_round++;
         @(negedge clk);
      end
      chk("t2_final_round", round4, 28);
      chk("t2_final_busy", busy4, 0);
      chk("t2_final_decph", dec_phase4, 1);
      chk("t2_mode", mode4, 2);
      chk("t2_nr", nr4, 14);

      // T3: illegal key size in IDLE
      start = 1'b1; key_sel = 2'd3;
      @(negedge clk);
      start = 1'b0;
      chk("t3_err", err, 1);
      chk("t3_round", round, 0);
      chk("t3_busy", busy, 0);
      chk("t3_mode", mode, 0);
      chk("t3_encph", enc_phase, 0);
      @(negedge clk);
      chk("t3_err_pulse", err, 0);
      chk("t3_idle_busy", busy, 0);

      // T1: AES-128 full rate
      run("t1", 2'd0, 10, -1);
      // T4: AES-192 with ignored start mid-run (from HOLD)
      run("t4", 2'd1, 12, 5);
      // AES-256 to HOLD, then T6: restart as AES-128 from HOLD
      run("t6pre", 2'd2, 14, -1);
      run("t6", 2'd0, 10, -1);

      // T5: reset at round 7 of AES-192, together with start
      start = 1'b1; key_sel = 2'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("t5_round7", round, 7);
      rst = 1'b1; start = 1'b1; key_sel = 2'd2;
      @(negedge clk);
      chk_reset_state("t5");
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("t5_idle_round", round, 0);
      chk("t5_idle_busy", busy, 0);
      chk("t5_idle_encph", enc_phase, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
